// File: rtl/fmem_pkg.sv
// Shared types for the frame-buffer bus target: bus commands, FSM states, burst length decode.
package fmem_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE  = 3'b000,
        CMD_WDATA = 3'b001,
        CMD_RREQ  = 3'b010,
        CMD_RDATA = 3'b011,
        CMD_WREQ  = 3'b100,
        CMD_WRESP = 3'b101,
        CMD_ERR   = 3'b111
    } bus_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ARB,
        ST_RD_DATA,
        ST_WR_ARB,
        ST_WR_RESP,
        ST_WR_DATA
    } fmem_state_e;

    localparam logic [1:0] REQ_BID  = 2'b11;
    localparam logic [1:0] REQ_NONE = 2'b00;

    function automatic logic [3:0] len2beats(input logic [1:0] len);
        return 4'd1 << len;
    endfunction

endpackage

// File: rtl/fmem_if.sv
// Video bus signals seen by a target; master drives requests/grant, slave answers.
interface fmem_if;
    logic        selin;
    logic [2:0]  cmdin;
    logic [1:0]  lenin;
    logic [31:0] addrdatain;
    logic        ackin;
    logic [1:0]  reqout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic [2:0]  cmdout;
    logic [3:0]  reqtar;

    modport slave (
        input  selin, cmdin, lenin, addrdatain, ackin,
        output reqout, lenout, addrdataout, cmdout, reqtar
    );
    modport master (
        output selin, cmdin, lenin, addrdatain, ackin,
        input  reqout, lenout, addrdataout, cmdout, reqtar
    );
endinterface

// File: rtl/fmem_ram.sv
// Single-port synchronous RAM, read-first: a read of the word being written returns old data.
module fmem_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fmem_target.sv
// Frame-buffer bus target: serves burst reads and writes over the video bus.
// Define FMEM_ERR_RESP_EN to answer out-of-window / misaligned requests with cmd 111.
module fmem_target
    import fmem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [3:0]  MASTER_ID = 4'h1,
    parameter logic [31:0] BASE      = 32'h0000_0000
) (
    input logic   clk,
    input logic   reset,
    fmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    fmem_state_e   state_q;
    logic [AW-1:0] idx_q;
    logic [1:0]    len_q;
    logic [3:0]    k_q;
    logic [31:0]   addr_q;
    logic          err_q;

    logic [1:0]    reqout_q;
    logic [1:0]    lenout_q;
    logic [31:0]   data_q;
    bus_cmd_e      cmd_q;
    logic [3:0]    reqtar_q;

    logic [31:0]   off;
    logic [AW-1:0] in_idx;
    logic [3:0]    beats;
    logic [3:0]    k_nx;
    logic          addr_bad;
    logic          wr_beat;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    assign off    = bus.addrdatain - BASE;
    assign in_idx = AW'(off >> 2);
    assign beats  = len2beats(len_q);

`ifdef FMEM_ERR_RESP_EN
    assign addr_bad = (off >= 32'(4 * DEPTH)) || (bus.addrdatain[1:0] != 2'b00);
`else
    assign addr_bad = 1'b0;
`endif

    assign wr_beat = (state_q == ST_WR_DATA) && bus.selin && (bus.cmdin == CMD_WDATA);

    // The RAM read is registered, so the address runs one beat ahead of the output register.
    assign k_nx = (state_q == ST_RD_ARB) ? {3'b000, bus.ackin} : k_q + 4'd1;

    always_comb begin
        ram_addr = idx_q + AW'(k_nx);
        if (state_q == ST_IDLE)         ram_addr = in_idx;
        else if (state_q == ST_WR_DATA) ram_addr = idx_q + AW'(k_q);
    end

    fmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i   (clk),
        .we_i    (wr_beat),
        .addr_i  (ram_addr),
        .wdata_i (bus.addrdatain),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            k_q      <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            reqout_q <= REQ_NONE;
            lenout_q <= '0;
            data_q   <= '0;
            cmd_q    <= CMD_IDLE;
            reqtar_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    reqout_q <= REQ_NONE;
                    lenout_q <= '0;
                    data_q   <= '0;
                    cmd_q    <= CMD_IDLE;
                    reqtar_q <= '0;
                    k_q      <= '0;
                    if (bus.selin && (bus.cmdin == CMD_RREQ || bus.cmdin == CMD_WREQ)) begin
                        idx_q    <= in_idx;
                        len_q    <= bus.lenin;
                        addr_q   <= bus.addrdatain;
                        err_q    <= addr_bad;
                        reqout_q <= REQ_BID;
                        reqtar_q <= MASTER_ID;
                        state_q  <= (bus.cmdin == CMD_RREQ) ? ST_RD_ARB : ST_WR_ARB;
                    end
                end
                ST_RD_ARB: if (bus.ackin) begin
                    reqout_q <= REQ_NONE;
                    if (err_q) begin
                        cmd_q   <= CMD_ERR;
                        data_q  <= addr_q;
                        state_q <= ST_IDLE;
                    end else begin
                        cmd_q    <= CMD_RDATA;
                        lenout_q <= len_q;
                        data_q   <= ram_rdata;
                        k_q      <= 4'd1;
                        state_q  <= (beats == 4'd1) ? ST_IDLE : ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    data_q <= ram_rdata;
                    k_q    <= k_q + 4'd1;
                    if (k_q + 4'd1 == beats) state_q <= ST_IDLE;
                end
                ST_WR_ARB: if (bus.ackin) begin
                    reqout_q <= REQ_NONE;
                    if (err_q) begin
                        cmd_q   <= CMD_ERR;
                        data_q  <= addr_q;
                        state_q <= ST_IDLE;
                    end else begin
                        cmd_q   <= CMD_WRESP;
                        state_q <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    cmd_q    <= CMD_IDLE;
                    reqtar_q <= '0;
                    state_q  <= ST_WR_DATA;
                end
                ST_WR_DATA: if (wr_beat) begin
                    k_q <= k_q + 4'd1;
                    if (k_q + 4'd1 == beats) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.reqout      = reqout_q;
    assign bus.lenout      = lenout_q;
    assign bus.addrdataout = data_q;
    assign bus.cmdout      = cmd_q;
    assign bus.reqtar      = reqtar_q;
endmodule

// File: tb/tb_fmem_target.sv
// Directed bench for fmem_target: writes, burst reads, wrap, stall, busy-ignore, reset mid-burst.
module tb_fmem_target;
    import fmem_pkg::*;

    typedef logic [31:0] vec_t [8];

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    vec_t v;

    fmem_if bus ();

    fmem_target #(.DEPTH(1024), .MASTER_ID(4'h1), .BASE(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [2:0] cmd, input logic [1:0] len,
                         input logic [31:0] ad);
        bus.selin      = sel;
        bus.cmdin      = cmd;
        bus.lenin      = len;
        bus.addrdatain = ad;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cmd"},    32'(bus.cmdout),     32'h0);
        chk({tag, "_data"},   bus.addrdataout,      32'h0);
        chk({tag, "_reqout"}, 32'(bus.reqout),     32'h0);
        chk({tag, "_lenout"}, 32'(bus.lenout),     32'h0);
        chk({tag, "_reqtar"}, 32'(bus.reqtar),     32'h0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [1:0] len,
                           input int ack_dly, input vec_t exp);
        int n;
        n = 1 << len;
        drive(1'b1, CMD_RREQ, len, addr);
        tick();
        drive(1'b0, CMD_IDLE, 2'b00, 32'h0);
        for (int i = 0; i < ack_dly; i++) begin
            chk({tag, "_bid"}, 32'(bus.reqout), 32'h3);
            tick();
        end
        chk({tag, "_bid"},    32'(bus.reqout), 32'h3);
        chk({tag, "_bidtar"}, 32'(bus.reqtar), 32'h1);
        bus.ackin = 1'b1;
        tick();
        bus.ackin = 1'b0;
        for (int b = 0; b < n; b++) begin
            chk({tag, "_rcmd"},   32'(bus.cmdout), 32'h3);
            chk({tag, "_rlen"},   32'(bus.lenout), 32'(len));
            chk({tag, "_rdata"},  bus.addrdataout,  exp[b]);
            chk({tag, "_rtar"},   32'(bus.reqtar), 32'h1);
            chk({tag, "_rnobid"}, 32'(bus.reqout), 32'h0);
            tick();
        end
        chk({tag, "_endcmd"},  32'(bus.cmdout), 32'h0);
        chk({tag, "_enddata"}, bus.addrdataout,  32'h0);
        chk({tag, "_endtar"},  32'(bus.reqtar), 32'h0);
    endtask

    // stall_after: beat index followed by one idle cycle (-1 for none)
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [1:0] len,
                            input int ack_dly, input vec_t d, input int stall_after,
                            input bit inject_rreq);
        int n;
        n = 1 << len;
        drive(1'b1, CMD_WREQ, len, addr);
        tick();
        drive(1'b0, CMD_IDLE, 2'b00, 32'h0);
        for (int i = 0; i < ack_dly; i++) begin
            chk({tag, "_bid"}, 32'(bus.reqout), 32'h3);
            tick();
        end
        chk({tag, "_bid"}, 32'(bus.reqout), 32'h3);
        bus.ackin = 1'b1;
        tick();
        bus.ackin = 1'b0;
        chk({tag, "_resp"},   32'(bus.cmdout), 32'h5);
        chk({tag, "_nobid"},  32'(bus.reqout), 32'h0);
        tick();
        chk({tag, "_resp1"},  32'(bus.cmdout), 32'h0);
        if (inject_rreq) begin
            drive(1'b1, CMD_RREQ, 2'b00, 32'h0);
            tick();
            chk({tag, "_busybid"}, 32'(bus.reqout), 32'h0);
            chk({tag, "_busycmd"}, 32'(bus.cmdout), 32'h0);
        end
        for (int b = 0; b < n; b++) begin
            drive(1'b1, CMD_WDATA, 2'b00, d[b]);
            tick();
            if (b == stall_after) begin
                drive(1'b1, CMD_IDLE, 2'b00, 32'hBAD0_BAD0);
                tick();
            end
        end
        drive(1'b0, CMD_IDLE, 2'b00, 32'h0);
        tick();
        chk({tag, "_donebid"}, 32'(bus.reqout), 32'h0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        bus.ackin = 1'b0;
        drive(1'b0, CMD_IDLE, 2'b00, 32'h0);
        reset = 1'b1;
        #1;
        chk_quiet("rst");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // single write then read-back
        v = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
        do_write("wr1", 32'h10, 2'b00, 1, v, -1, 1'b0);
        do_read("rd1", 32'h10, 2'b00, 0, v);

        // preload mem[0..3], burst read with grant delayed
        v = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0};
        do_write("pre", 32'h0, 2'b10, 0, v, -1, 1'b0);
        do_read("rd4", 32'h0, 2'b10, 2, v);

        // reset during beat 2 of 4
        drive(1'b1, CMD_RREQ, 2'b10, 32'h0);
        tick();
        drive(1'b0, CMD_IDLE, 2'b00, 32'h0);
        bus.ackin = 1'b1;
        tick();
        bus.ackin = 1'b0;
        chk("mid_b0", bus.addrdataout, 32'hA0);
        tick();
        chk("mid_b1", bus.addrdataout, 32'hA1);
        tick();
        chk("mid_b2", bus.addrdataout, 32'hA2);
        #2 reset = 1'b1;
        #1;
        chk_quiet("midrst");
        tick();
        reset = 1'b0;
        tick();
        chk_quiet("postrst");
        do_read("rdrst", 32'h0, 2'b10, 1, v);

        // wrapping 2-beat write with a stall, read back across the wrap
        v = '{32'h1111_1111, 32'h2222_2222, 0, 0, 0, 0, 0, 0};
        do_write("wrap", 32'hFFC, 2'b01, 0, v, 0, 1'b0);
        v = '{32'h1111_1111, 32'h2222_2222, 32'hA1, 32'hA2, 0, 0, 0, 0};
        do_read("rdwrap", 32'hFFC, 2'b10, 0, v);

        // read request during WR_DATA is ignored
        v = '{32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0};
        do_write("busy", 32'h20, 2'b00, 0, v, -1, 1'b1);
        do_read("rdbusy", 32'h20, 2'b00, 0, v);

        // out-of-window read
`ifdef FMEM_ERR_RESP_EN
        drive(1'b1, CMD_RREQ, 2'b00, 32'h2000);
        tick();
        drive(1'b0, CMD_IDLE, 2'b00, 32'h0);
        chk("err_bid", 32'(bus.reqout), 32'h3);
        bus.ackin = 1'b1;
        tick();
        bus.ackin = 1'b0;
        chk("err_cmd",  32'(bus.cmdout), 32'h7);
        chk("err_addr", bus.addrdataout,  32'h2000);
        tick();
        chk("err_end",  32'(bus.cmdout), 32'h0);
        chk("err_endd", bus.addrdataout,  32'h0);
`else
        v = '{32'h2222_2222, 0, 0, 0, 0, 0, 0, 0};
        do_read("rdoob", 32'h2000, 2'b00, 0, v);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
